pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RV32I core.
- Generates per-cycle stall, hold and flush controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Sources of those controls: load-use hazards, EX-stage redirects (taken branch, jal, jalr), multi-cycle data-memory waits, and a post-reset boot hold.
- Drives idex_flush into id_ex and keeps per-cause event counters for performance debug.

Parameters:
- BOOT_CYCLES, 4: cycles after reset release during which fetch is held off.
- MEM_TIMEOUT, 255: maximum consecutive MEM_WAIT cycles before mem_err is set.
- CNT_W, 32: width of the event counters.

Ports:
- clk  in  1  pipeline clock
- rstn  in  1  asynchronous active-low reset
- memread_ex  in  1  EX-stage instruction is a load
- rd_ex  in  5  EX-stage destination register
- rs_id  in  5  ID-stage source register 1
- rt_id  in  5  ID-stage source register 2
- use_rs_id  in  1  ID instruction reads rs
- use_rt_id  in  1  ID instruction reads rt
- branch_taken_ex  in  1  EX branch resolved taken
- jmp_ex  in  1  EX instruction is jal
- jalr_ex  in  1  EX instruction is jalr
- mem_req  in  1  MEM stage holds a load or store
- mem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC register enable
- pc_sel_redirect  out  1  PC loads the EX redirect target
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID loads a bubble
- idex_flush  out  1  ID/EX loads a bubble (control bits cleared)
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB
- mem_err  out  1  sticky memory timeout flag
- stall_cnt  out  CNT_W  load-use stall cycles
- flush_cnt  out  CNT_W  redirect events
- memwait_cnt  out  CNT_W  MEM_WAIT cycles

Behaviour:
- Reset is asynchronous and active-low: clk and rstn, with rstn low forcing every register and output to its reset value immediately.
- Reset values:
  - state = BOOT, boot counter = 0.
  - pc_write = ifid_write = pc_sel_redirect = 0.
  - ifid_flush = idex_flush = 1.
  - pipe_hold = 0, mem_err = 0, all counters = 0.
- Control outputs are combinational from state and inputs (zero latency). State and counters are registered.
- States:
  - BOOT: pc_write = 0, ifid_write = 0, ifid_flush = 1, idex_flush = 1. The boot counter increments every cycle; when it reaches BOOT_CYCLES-1, go to RUN.
  - RUN: apply the priority rules below. If mem_req && !mem_ready, go to MEM_WAIT in the same cycle in which the hold is asserted.
  - MEM_WAIT:
    - pipe_hold = 1, pc_write = 0, ifid_write = 0, no flushes.
    - The wait counter increments each cycle.
    - When mem_ready = 1: release the hold in that cycle and return to RUN next cycle. The controls for that cycle are computed as in RUN.
    - When the wait counter reaches MEM_TIMEOUT: set mem_err (sticky until reset) and stay in MEM_WAIT.
- RUN priority, highest first:
  1. Memory wait (mem_req && !mem_ready): pipe_hold = 1, pc_write = 0, ifid_write = 0. Redirect and load-use are suppressed this cycle. Instructions are frozen in place, so these events re-evaluate after the wait.
  2. Redirect (branch_taken_ex | jmp_ex | jalr_ex): pc_write = 1, pc_sel_redirect = 1, ifid_flush = 1, idex_flush = 1. flush_cnt += 1. A load-use hazard in the same cycle is ignored, because the ID instruction is squashed.
  3. Load-use: memread_ex && rd_ex != 0 && ((use_rs_id && rs_id == rd_ex) || (use_rt_id && rt_id == rd_ex)). Then pc_write = 0, ifid_write = 0, idex_flush = 1. stall_cnt += 1. Exactly one bubble; the next cycle re-evaluates normally.
  4. Otherwise: pc_write = 1, ifid_write = 1, no flush, no hold.
- memwait_cnt increments on every cycle with pipe_hold = 1.
- All counters saturate at all-ones and do not wrap.
- rd_ex = x0 never causes a stall.
- Reset mid-MEM_WAIT or mid-BOOT returns to BOOT with the reset values above.

Decomposition:
- Shared package pipe_pkg:
  - state encoding (BOOT = 2'd0, RUN = 2'd1, MEM_WAIT = 2'd2)
  - REG_ZERO = 5'd0
  - defaults for BOOT_CYCLES and MEM_TIMEOUT
- Sub-module sat_counter: parameterised width, with inc and clear inputs and a saturating output. It is instantiated three times for the event counters.

Test Plan:
- Reset release: with BOOT_CYCLES = 4, pc_write = 0 for 4 cycles after rstn rises, then 1 with ifid_flush = 0.
- Load-use: memread_ex = 1, rd_ex = 5, rs_id = 5, use_rs_id = 1 → one cycle of pc_write = 0, ifid_write = 0, idex_flush = 1, and stall_cnt = 1. Repeat with rd_ex = 0 → no stall.
- Redirect with a simultaneous load-use: branch_taken_ex = 1 plus hazard → pc_sel_redirect = 1, ifid_flush = idex_flush = 1, pc_write = 1, flush_cnt = 1, stall_cnt unchanged.
- Memory wait: mem_req = 1 with mem_ready low for 3 cycles then high → pipe_hold = 1 for 3 cycles, released in the ready cycle, memwait_cnt = 3. A concurrent jalr_ex is deferred until after the release.
- Timeout: MEM_TIMEOUT = 8 with mem_ready held low → mem_err rises after the 8th wait cycle and stays 1 after mem_ready rises.
- Asynchronous reset asserted mid-MEM_WAIT → outputs take their reset values immediately with no clock edge, and the BOOT sequence restarts.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings and defaults for the RV32I pipeline sequencer.
// Latency: n/a (declarations only); backpressure: n/a.
package pipe_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int BOOT_CYCLES_DEF = 4;
  localparam int MEM_TIMEOUT_DEF = 255;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Latency: count visible the cycle after i_inc; backpressure: none (i_inc is a pulse per event).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_inc,
  input  logic         i_clear,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: PC/IF/ID/EX stall, flush and hold from load-use, redirects, memory waits and boot hold.
// Latency: controls are combinational (zero cycles); backpressure: mem_req without mem_ready freezes the whole pipe.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int BOOT_CYCLES = BOOT_CYCLES_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             memread_ex,
  input  logic [4:0]       rd_ex,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic             branch_taken_ex,
  input  logic             jmp_ex,
  input  logic             jalr_ex,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_sel_redirect,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_hold,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(MEM_TIMEOUT);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [BW-1:0] r_boot_cnt;
  logic [TW-1:0] r_wait_cnt;
  logic          r_mem_err;

  logic w_redirect;
  logic w_load_use;
  logic w_mem_wait;
  logic w_stall_evt;
  logic w_flush_evt;

  assign w_redirect = branch_taken_ex | jmp_ex | jalr_ex;
  assign w_load_use = memread_ex && (rd_ex != REG_ZERO) &&
                      ((use_rs_id && (rs_id == rd_ex)) || (use_rt_id && (rt_id == rd_ex)));
  // Once waiting, only mem_ready releases the hold; the frozen MEM op is still pending.
  assign w_mem_wait = (r_state == MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);

  always_comb begin
    w_state_nxt     = r_state;
    pc_write        = 1'b0;
    pc_sel_redirect = 1'b0;
    ifid_write      = 1'b0;
    ifid_flush      = 1'b0;
    idex_flush      = 1'b0;
    pipe_hold       = 1'b0;
    w_stall_evt     = 1'b0;
    w_flush_evt     = 1'b0;

    case (r_state)
      BOOT: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (r_boot_cnt == BOOT_LAST) begin
          w_state_nxt = RUN;
        end
      end
      RUN, MEM_WAIT: begin
        if (w_mem_wait) begin
          pipe_hold   = 1'b1;
          w_state_nxt = MEM_WAIT;
        end else begin
          w_state_nxt = RUN;
          if (w_redirect) begin
            pc_write        = 1'b1;
            pc_sel_redirect = 1'b1;
            ifid_write      = 1'b1;
            ifid_flush      = 1'b1;
            idex_flush      = 1'b1;
            w_flush_evt     = 1'b1;
          end else if (w_load_use) begin
            idex_flush  = 1'b1;
            w_stall_evt = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= BOOT;
      r_boot_cnt <= '0;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == BOOT) begin
        r_boot_cnt <= r_boot_cnt + 1'b1;
      end
      // r_wait_cnt counts hold cycles already completed; this edge completes one more.
      if (pipe_hold) begin
        if (r_wait_cnt != TIMEOUT_V) begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
        end
        if (r_wait_cnt == (TIMEOUT_V - 1'b1)) begin
          r_mem_err <= 1'b1;
        end
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  assign mem_err = r_mem_err;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .i_inc   (w_stall_evt),
    .i_clear (1'b0),
    .o_cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .i_inc   (w_flush_evt),
    .i_clear (1'b0),
    .o_cnt   (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_memwait_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .i_inc   (pipe_hold),
    .i_clear (1'b0),
    .o_cnt   (memwait_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a rule-level model.
module tb_pipe_hazard_ctrl;

  localparam int BOOT_N = 4;
  localparam int TMO    = 8;
  localparam int CW     = 4;
  localparam int CMAX   = 15;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          memread_ex, use_rs_id, use_rt_id;
  logic [4:0]    rd_ex, rs_id, rt_id;
  logic          branch_taken_ex, jmp_ex, jalr_ex, mem_req, mem_ready;
  logic          pc_write, pc_sel_redirect, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt, memwait_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.BOOT_CYCLES(BOOT_N), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .memread_ex(memread_ex), .rd_ex(rd_ex), .rs_id(rs_id), .rt_id(rt_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .branch_taken_ex(branch_taken_ex), .jmp_ex(jmp_ex),
    .jalr_ex(jalr_ex), .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write),
    .pc_sel_redirect(pc_sel_redirect), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .pipe_hold(pipe_hold), .mem_err(mem_err), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: boot cycles left, whether a memory access is outstanding, hold length, counters.
  int m_boot_left, m_wait, m_stall, m_flush, m_mwait;
  bit m_in_wait, m_err, m_hold, m_redir, m_lu;

  // ctrl vector: {pc_write, pc_sel_redirect, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_err}
  logic [6:0]  exp_ctrl, obs_ctrl, mask;
  logic [11:0] exp_cnt, obs_cnt;

  localparam logic [6:0] P_BOOT   = 7'b0001100;
  localparam logic [6:0] P_NORMAL = 7'b1010000;
  localparam logic [6:0] P_LU     = 7'b0000100;
  localparam logic [6:0] P_REDIR  = 7'b1101100;
  localparam logic [6:0] P_HOLD   = 7'b0000010;
  localparam logic [6:0] M_REDIR  = 7'b1101111;

  task automatic model_reset();
    m_boot_left = BOOT_N;
    m_in_wait = 0; m_wait = 0; m_err = 0;
    m_stall = 0; m_flush = 0; m_mwait = 0;
  endtask

  task automatic drive_idle();
    memread_ex = 0; rd_ex = 0; rs_id = 0; rt_id = 0; use_rs_id = 0; use_rt_id = 0;
    branch_taken_ex = 0; jmp_ex = 0; jalr_ex = 0; mem_req = 0; mem_ready = 0;
  endtask

  // Move to the falling edge and work out what this cycle must look like.
  task automatic settle();
    bit hazard;
    @(negedge clk);
    hazard = memread_ex && (rd_ex != 0) &&
             ((use_rs_id && rs_id == rd_ex) || (use_rt_id && rt_id == rd_ex));
    mask = 7'h7F; m_hold = 0; m_redir = 0; m_lu = 0;
    if (m_boot_left > 0) begin
      exp_ctrl = {6'b000110, m_err};
    end else begin
      m_hold = m_in_wait ? !mem_ready : (mem_req && !mem_ready);
      if (m_hold) exp_ctrl = {6'b000001, m_err};
      else if (branch_taken_ex || jmp_ex || jalr_ex) begin
        m_redir = 1; exp_ctrl = {6'b111110, m_err}; mask = M_REDIR;
      end else if (hazard) begin
        m_lu = 1; exp_ctrl = {6'b000010, m_err};
      end else exp_ctrl = {6'b101000, m_err};
    end
    exp_cnt  = {4'(m_stall), 4'(m_flush), 4'(m_mwait)};
    obs_ctrl = {pc_write, pc_sel_redirect, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_err};
    obs_cnt  = {stall_cnt, flush_cnt, memwait_cnt};
  endtask

  task automatic advance();
    @(posedge clk);
    if (m_boot_left > 0) m_boot_left--;
    else if (m_hold) begin
      m_in_wait = 1; m_wait++;
      if (m_wait >= TMO) m_err = 1;
      if (m_mwait < CMAX) m_mwait++;
    end else begin
      m_in_wait = 0; m_wait = 0;
      if (m_redir && m_flush < CMAX) m_flush++;
      if (m_lu && m_stall < CMAX) m_stall++;
    end
    #1;
  endtask

  task automatic test_reset();
    #12;
    obs_ctrl = {pc_write, pc_sel_redirect, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_err};
    obs_cnt  = {stall_cnt, flush_cnt, memwait_cnt};
    checks++;
    if (obs_ctrl !== P_BOOT) begin errors++; $display("FAIL reset_ctrl got %b want %b", obs_ctrl, P_BOOT); end
    checks++;
    if (obs_cnt !== 12'h0) begin errors++; $display("FAIL reset_cnt got %h want 000", obs_cnt); end
    @(posedge clk); #1;
    rstn = 1;
  endtask

  task automatic test_boot();
    for (int i = 0; i < 6; i++) begin
      settle();
      checks++;
      if (obs_ctrl !== exp_ctrl) begin errors++; $display("FAIL boot_ctrl[%0d] got %b want %b", i, obs_ctrl, exp_ctrl); end
      checks++;
      if (pc_write !== (i >= BOOT_N) || ifid_flush !== (i < BOOT_N)) begin
        errors++; $display("FAIL boot_pc_write[%0d] got pc_write=%b ifid_flush=%b want %b %b", i, pc_write, ifid_flush, i >= BOOT_N, i < BOOT_N);
      end
      advance();
    end
  endtask

  task automatic test_load_use();
    memread_ex = 1; rd_ex = 5; rs_id = 5; use_rs_id = 1;
    settle();
    checks++;
    if (obs_ctrl !== P_LU) begin errors++; $display("FAIL lu_stall got %b want %b", obs_ctrl, P_LU); end
    advance();
    drive_idle();
    settle();
    checks++;
    if (obs_ctrl !== P_NORMAL || stall_cnt !== 4'd1) begin
      errors++; $display("FAIL lu_one_bubble got %b cnt %0d want %b cnt 1", obs_ctrl, stall_cnt, P_NORMAL);
    end
    advance();
    memread_ex = 1; rd_ex = 0; rs_id = 0; use_rs_id = 1;
    settle();
    checks++;
    if (obs_ctrl !== P_NORMAL || obs_cnt !== exp_cnt) begin
      errors++; $display("FAIL lu_x0 got %b cnt %h want %b cnt %h", obs_ctrl, obs_cnt, P_NORMAL, exp_cnt);
    end
    advance();
    rd_ex = 7; rt_id = 7; use_rt_id = 1; use_rs_id = 0;
    settle();
    checks++;
    if (obs_ctrl !== P_LU) begin errors++; $display("FAIL lu_rt got %b want %b", obs_ctrl, P_LU); end
    advance();
    use_rt_id = 0;
    settle();
    checks++;
    if (obs_ctrl !== P_NORMAL || stall_cnt !== 4'd2) begin
      errors++; $display("FAIL lu_rt_unused got %b cnt %0d want %b cnt 2", obs_ctrl, stall_cnt, P_NORMAL);
    end
    advance();
    drive_idle();
  endtask

  task automatic test_redirect();
    branch_taken_ex = 1; memread_ex = 1; rd_ex = 5; rs_id = 5; use_rs_id = 1;
    settle();
    checks++;
    if ((obs_ctrl & M_REDIR) !== P_REDIR) begin errors++; $display("FAIL redir_ctrl got %b want %b", obs_ctrl & M_REDIR, P_REDIR); end
    advance();
    drive_idle();
    settle();
    checks++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd2 || obs_cnt !== exp_cnt) begin
      errors++; $display("FAIL redir_cnt got %h want flush 1 stall 2 (%h)", obs_cnt, exp_cnt);
    end
    advance();
  endtask

  task automatic test_mem_wait();
    mem_req = 1; mem_ready = 0; jalr_ex = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (obs_ctrl !== P_HOLD || obs_ctrl !== exp_ctrl) begin
        errors++; $display("FAIL memwait_hold[%0d] got %b want %b", i, obs_ctrl, P_HOLD);
      end
      advance();
    end
    mem_ready = 1;
    settle();
    checks++;
    if ((obs_ctrl & M_REDIR) !== P_REDIR) begin errors++; $display("FAIL memwait_release got %b want %b", obs_ctrl & M_REDIR, P_REDIR); end
    advance();
    drive_idle();
    settle();
    checks++;
    if (memwait_cnt !== 4'd3 || flush_cnt !== 4'd2 || obs_cnt !== exp_cnt) begin
      errors++; $display("FAIL memwait_cnt got %h want memwait 3 flush 2 (%h)", obs_cnt, exp_cnt);
    end
    advance();
  endtask

  task automatic test_timeout();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 10; i++) begin
      settle();
      checks++;
      if (obs_ctrl !== {6'b000001, i >= TMO} || obs_ctrl !== exp_ctrl) begin
        errors++; $display("FAIL timeout[%0d] got %b want %b", i, obs_ctrl, {6'b000001, i >= TMO});
      end
      advance();
    end
    mem_ready = 1;
    settle();
    checks++;
    if (obs_ctrl !== 7'b1010001) begin errors++; $display("FAIL timeout_release got %b want 1010001", obs_ctrl); end
    advance();
    drive_idle();
    settle();
    checks++;
    if (mem_err !== 1'b1 || obs_cnt !== exp_cnt) begin
      errors++; $display("FAIL timeout_sticky got err %b cnt %h want 1 %h", mem_err, obs_cnt, exp_cnt);
    end
    advance();
  endtask

  task automatic test_async_reset();
    mem_req = 1; mem_ready = 0;
    settle(); advance();
    settle(); advance();
    #2 rstn = 0;
    #1;
    obs_ctrl = {pc_write, pc_sel_redirect, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_err};
    obs_cnt  = {stall_cnt, flush_cnt, memwait_cnt};
    checks++;
    if (obs_ctrl !== P_BOOT || obs_cnt !== 12'h0) begin
      errors++; $display("FAIL async_reset got %b cnt %h want %b cnt 000", obs_ctrl, obs_cnt, P_BOOT);
    end
    model_reset();
    drive_idle();
    @(posedge clk); #1;
    rstn = 1;
    for (int i = 0; i < 6; i++) begin
      settle();
      checks++;
      if (obs_ctrl !== exp_ctrl || pc_write !== (i >= BOOT_N)) begin
        errors++; $display("FAIL reboot[%0d] got %b want %b", i, obs_ctrl, exp_ctrl);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      memread_ex      = 1'($urandom_range(0, 1));
      rd_ex           = 5'($urandom_range(0, 3));
      rs_id           = 5'($urandom_range(0, 3));
      rt_id           = 5'($urandom_range(0, 3));
      use_rs_id       = 1'($urandom_range(0, 1));
      use_rt_id       = 1'($urandom_range(0, 1));
      branch_taken_ex = ($urandom_range(0, 7) == 0);
      jmp_ex          = ($urandom_range(0, 11) == 0);
      jalr_ex         = ($urandom_range(0, 11) == 0);
      mem_req         = ($urandom_range(0, 2) == 0);
      mem_ready       = 1'($urandom_range(0, 1));
      settle();
      checks++;
      if ((obs_ctrl & mask) !== (exp_ctrl & mask)) begin
        errors++; $display("FAIL rand_ctrl[%0d] got %b want %b", i, obs_ctrl & mask, exp_ctrl & mask);
      end
      checks++;
      if (obs_cnt !== exp_cnt) begin
        errors++; $display("FAIL rand_cnt[%0d] got %h want %h", i, obs_cnt, exp_cnt);
      end
      advance();
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_boot();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
